// File: rtl/mod_counter_seq_ctrl_if.sv
// Control/status bundle for the mod-N counter sequencer.
// master drives start/stop/pause/cfg_*; slave returns Q/tick/busy/done.
interface mod_counter_seq_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int PER_W = 8
);
  logic             start;
  logic             stop;
  logic             pause;
  logic [CNT_W-1:0] cfg_limit;
  logic [PER_W-1:0] cfg_periods;
  logic [CNT_W-1:0] Q;
  logic             tick;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pause, cfg_limit, cfg_periods,
    input  Q, tick, busy, done
  );

  modport slave (
    input  start, stop, pause, cfg_limit, cfg_periods,
    output Q, tick, busy, done
  );
endinterface

// File: rtl/mod_counter_seq_ctrl.sv
// Sequencer for a mod-N counter: arms, runs, pauses, aborts, completes.
// Ports: clk, rst (sync, active-high), bus (slave: cmds/cfg in, Q/tick/busy/done out).
module mod_counter_seq_ctrl #(
  parameter int N     = 10,
  parameter int CNT_W = $clog2(N),
  parameter int PER_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mod_counter_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LIM_MAX = CNT_W'(N - 1);
  localparam logic [CNT_W:0]   N_EXT   = (CNT_W + 1)'(N);
  localparam logic [PER_W-1:0] WRAP_SAT = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic [PER_W-1:0] wrap_q, wrap_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] lim_clamped;

  // Zero or out-of-range limit selects the full modulus.
  always_comb begin
    lim_clamped = bus.cfg_limit;
    if (bus.cfg_limit == '0 || {1'b0, bus.cfg_limit} >= N_EXT)
      lim_clamped = LIM_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= '0;
      lim_q   <= LIM_MAX;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      lim_q   <= lim_d;
      per_q   <= per_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tick_d  = 1'b0;
    wrap_d  = wrap_q;
    lim_d   = lim_q;
    per_d   = per_q;
    unique case (state_q)
      IDLE: begin
        q_d = '0;
        if (bus.start && !bus.stop) begin
          lim_d   = lim_clamped;
          per_d   = bus.cfg_periods;
          wrap_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          q_d     = '0;
        end else if (bus.pause) begin
          state_d = HOLD;
        end else if (q_q != lim_q) begin
          q_d = q_q + CNT_W'(1);
        end else begin
          q_d    = '0;
          tick_d = 1'b1;
          // Saturate so a free-running count never rolls over.
          if (wrap_q != WRAP_SAT)
            wrap_d = wrap_q + PER_W'(1);
          if (per_q != '0 && wrap_q == per_q - PER_W'(1))
            state_d = DONE;
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
          q_d     = '0;
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
        q_d     = '0;
      end
      default: begin
        state_d = IDLE;
        q_d     = '0;
      end
    endcase
  end

  assign bus.Q    = q_q;
  assign bus.tick = tick_q;
  assign bus.busy = (state_q == RUN) || (state_q == HOLD);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_mod_counter_seq_ctrl.sv
// Directed bench for mod_counter_seq_ctrl (N=10).
// Drives via the interface, samples 1 time unit after each posedge.
module tb_mod_counter_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mod_counter_seq_ctrl_if #(.CNT_W(4), .PER_W(8)) bus ();

  mod_counter_seq_ctrl #(.N(10), .CNT_W(4), .PER_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int lim, input int per);
    bus.cfg_limit   = 4'(lim);
    bus.cfg_periods = 8'(per);
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.pause       = 1'b0;
    bus.cfg_limit   = '0;
    bus.cfg_periods = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_q", bus.Q, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tick", bus.tick, 0);

    // limit 0 -> 9, two periods
    go(0, 2);
    chk("t2_q0", bus.Q, 0);
    chk("t2_busy0", bus.busy, 1);
    for (int c = 1; c <= 20; c++) begin
      step();
      chk($sformatf("t2_q%0d", c), bus.Q, c % 10);
      chk($sformatf("t2_tick%0d", c), bus.tick, (c % 10 == 0) ? 1 : 0);
      chk($sformatf("t2_done%0d", c), bus.done, (c == 20) ? 1 : 0);
      chk($sformatf("t2_busy%0d", c), bus.busy, (c == 20) ? 0 : 1);
    end
    step();
    chk("t2_idle_done", bus.done, 0);
    chk("t2_idle_busy", bus.busy, 0);
    chk("t2_idle_tick", bus.tick, 0);

    // limit 3 free-run; start held while busy and cfg changed mid-run
    go(3, 0);
    bus.cfg_limit = 4'd9;
    for (int c = 1; c <= 100; c++) begin
      bus.start = (c >= 40 && c <= 60);
      step();
      chk($sformatf("t3_q%0d", c), bus.Q, c % 4);
      chk($sformatf("t3_tick%0d", c), bus.tick, (c % 4 == 0) ? 1 : 0);
      chk($sformatf("t3_done%0d", c), bus.done, 0);
      chk($sformatf("t3_busy%0d", c), bus.busy, 1);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    step();
    bus.stop  = 1'b0;
    chk("t3_stop_q", bus.Q, 0);
    chk("t3_stop_busy", bus.busy, 0);

    // reset mid-run at Q=5
    go(9, 0);
    for (int c = 0; c < 5; c++) step();
    chk("t1_q5", bus.Q, 5);
    rst = 1'b1;
    step();
    chk("t1_rst_q", bus.Q, 0);
    chk("t1_rst_busy", bus.busy, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("t1_idle_q", bus.Q, 0);
    chk("t1_idle_busy", bus.busy, 0);

    // pause at Q=4 for five cycles
    go(9, 0);
    for (int c = 0; c < 4; c++) step();
    chk("t4_q4", bus.Q, 4);
    bus.pause = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("t4_hold_q%0d", c), bus.Q, 4);
      chk($sformatf("t4_hold_busy%0d", c), bus.busy, 1);
      chk($sformatf("t4_hold_tick%0d", c), bus.tick, 0);
    end
    bus.pause = 1'b0;
    step();
    chk("t4_resume_q", bus.Q, 4);
    step();
    chk("t4_count_q", bus.Q, 5);

    // stop in RUN at Q=7
    step();
    step();
    chk("t5_q7", bus.Q, 7);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("t5_run_stop_q", bus.Q, 0);
    chk("t5_run_stop_busy", bus.busy, 0);
    chk("t5_run_stop_tick", bus.tick, 0);
    chk("t5_run_stop_done", bus.done, 0);

    // stop in HOLD
    go(9, 0);
    for (int c = 0; c < 3; c++) step();
    bus.pause = 1'b1;
    step();
    chk("t5_hold_q", bus.Q, 3);
    bus.stop = 1'b1;
    step();
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    chk("t5_hold_stop_q", bus.Q, 0);
    chk("t5_hold_stop_busy", bus.busy, 0);
    chk("t5_hold_stop_done", bus.done, 0);
    step();
    chk("t5_still_idle", bus.busy, 0);

    // start+stop in IDLE ignored
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("t6_ss_busy", bus.busy, 0);

    // limit 15 clamps to 9; one period; start in DONE ignored
    go(15, 1);
    for (int c = 1; c <= 10; c++) begin
      step();
      chk($sformatf("t6_q%0d", c), bus.Q, c % 10);
      chk($sformatf("t6_done%0d", c), bus.done, (c == 10) ? 1 : 0);
    end
    chk("t6_wrap_tick", bus.tick, 1);
    chk("t6_done_busy", bus.busy, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t6_done_start_busy", bus.busy, 0);
    chk("t6_done_start_done", bus.done, 0);
    step();
    chk("t6_after_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
